// File: rtl/led_pkg.sv
// Shared types and sizing helpers for the LED bank arbiter slice.
package led_pkg;

    localparam int NLED_DEFAULT = 12;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        HOLD  = 2'd2,
        OPEN  = 2'd3
    } led_state_e;

    // Width able to hold MIN_DWELL-1; never narrower than one bit.
    function automatic int dwell_width(input int min_dwell);
        return (min_dwell > 1) ? $clog2(min_dwell) : 1;
    endfunction

    function automatic int index_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/led_bank_arbiter_if.sv
// Bundle between the pattern sources (master) and the LED bank arbiter (slave).
interface led_bank_arbiter_if
    import led_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int NLED = NLED_DEFAULT
);
    localparam int OW = index_width(NREQ);

    logic [NREQ-1:0]      req;
    logic [NREQ*NLED-1:0] pat;
    logic [NLED-1:0]      leds;
    logic [OW-1:0]        owner;
    logic                 owner_valid;
    logic                 switch_pulse;

    modport master (
        output req, pat,
        input  leds, owner, owner_valid, switch_pulse
    );

    modport slave (
        input  req, pat,
        output leds, owner, owner_valid, switch_pulse
    );

endinterface

// File: rtl/led_prio_enc.sv
// Masked fixed-priority encoder; the lowest set index wins.
module led_prio_enc
    import led_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IW   = index_width(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [NREQ-1:0] mask,
    output logic            any,
    output logic [IW-1:0]   idx
);

    always_comb begin
        any = 1'b0;
        idx = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req[i] && mask[i]) begin
                any = 1'b1;
                idx = IW'(i);
            end
        end
    end

endmodule

// File: rtl/led_bank_arbiter.sv
// Fixed-priority owner of the front-panel LED bank with minimum dwell and a
// one-cycle dark gap on every handover.
module led_bank_arbiter
    import led_pkg::*;
#(
    parameter int NREQ      = 4,
    parameter int NLED      = NLED_DEFAULT,
    parameter int MIN_DWELL = 1024
) (
    input  logic               clock,
    input  logic               reset,
    led_bank_arbiter_if.slave  bus
);

    localparam int OW = index_width(NREQ);
    localparam int DW = dwell_width(MIN_DWELL);

    led_state_e       state_q, state_d;
    logic [OW-1:0]    owner_q, owner_d;
    logic [DW-1:0]    cnt_q, cnt_d;

    logic [NLED-1:0]  leds_p1;
    logic             vld_p1;
    logic             pulse_p1;

    logic [NLED-1:0]  pat_arr [NREQ];
    logic [NREQ-1:0]  higher_mask;
    logic             hi_any, top_any;
    logic [OW-1:0]    hi_idx, top_idx;

    for (genvar g = 0; g < NREQ; g++) begin : g_pat
        assign pat_arr[g] = bus.pat[g*NLED +: NLED];
    end

    always_comb begin
        higher_mask = '0;
        for (int i = 0; i < NREQ; i++) begin
            higher_mask[i] = (i < int'(owner_q));
        end
    end

    // Anyone outranking the current owner.
    led_prio_enc #(.NREQ(NREQ), .IW(OW)) u_enc_higher (
        .req  (bus.req),
        .mask (higher_mask),
        .any  (hi_any),
        .idx  (hi_idx)
    );

    // Highest request overall; in OPEN it only matters once the owner and
    // everything above it are quiet, so it then yields the best lower source.
    led_prio_enc #(.NREQ(NREQ), .IW(OW)) u_enc_top (
        .req  (bus.req),
        .mask ({NREQ{1'b1}}),
        .any  (top_any),
        .idx  (top_idx)
    );

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (top_any) begin
                    state_d = BLANK;
                    owner_d = top_idx;
                end
            end
            BLANK: begin
                state_d = HOLD;
                cnt_d   = DW'(MIN_DWELL - 1);
            end
            HOLD: begin
                if (cnt_q == '0) state_d = OPEN;
                else             cnt_d   = cnt_q - 1'b1;
            end
            OPEN: begin
                if (hi_any) begin
                    state_d = BLANK;
                    owner_d = hi_idx;
                end else if (bus.req[owner_q]) begin
                    state_d = OPEN;
                end else if (top_any) begin
                    state_d = BLANK;
                    owner_d = top_idx;
                end else begin
                    state_d = IDLE;
                    owner_d = '0;
                end
            end
            default: begin
                state_d = IDLE;
                owner_d = '0;
            end
        endcase
    end

    // Output stage: drive decided from the next state so all pins are flops.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= IDLE;
            owner_q  <= '0;
            cnt_q    <= '0;
            leds_p1  <= '0;
            vld_p1   <= 1'b0;
            pulse_p1 <= 1'b0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            cnt_q    <= cnt_d;
            vld_p1   <= (state_d == HOLD) || (state_d == OPEN);
            pulse_p1 <= (state_d == BLANK);
            leds_p1  <= ((state_d == HOLD) || (state_d == OPEN)) ? pat_arr[owner_d] : '0;
        end
    end

    assign bus.leds         = leds_p1;
    assign bus.owner        = owner_q;
    assign bus.owner_valid  = vld_p1;
    assign bus.switch_pulse = pulse_p1;

endmodule

// File: tb/tb_led_bank_arbiter.sv
// Directed bench for led_bank_arbiter with NREQ=4, NLED=12, MIN_DWELL=4.
module tb_led_bank_arbiter;

    logic clock;
    logic reset;

    led_bank_arbiter_if #(.NREQ(4), .NLED(12)) bus ();

    led_bank_arbiter #(.NREQ(4), .NLED(12), .MIN_DWELL(4)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic        rst;
        logic [3:0]  req;
        logic [11:0] pat0;
        logic [11:0] leds;
        logic [1:0]  owner;
        logic        valid;
        logic        pulse;
    } vec_t;

    vec_t        vecs[$];
    logic [11:0] pats[4];
    int          errors = 0;
    int          checks = 0;
    int          pulses;

    task automatic add(input logic rst, input logic [3:0] req, input logic [11:0] pat0,
                       input logic [11:0] leds, input logic [1:0] owner,
                       input logic valid, input logic pulse);
        vec_t v;
        v.rst = rst; v.req = req; v.pat0 = pat0;
        v.leds = leds; v.owner = owner; v.valid = valid; v.pulse = pulse;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic drive_pats();
        bus.pat = {pats[3], pats[2], pats[1], pats[0]};
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check_all(input string tag, input logic [11:0] leds, input logic [1:0] owner,
                             input logic valid, input logic pulse);
        check({tag, ".leds"},  bus.leds,         leds);
        check({tag, ".owner"}, bus.owner,        owner);
        check({tag, ".valid"}, bus.owner_valid,  valid);
        check({tag, ".pulse"}, bus.switch_pulse, pulse);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        pats[0] = 12'hA5A; pats[1] = 12'h3C3; pats[2] = 12'h00F; pats[3] = 12'hF00;
        reset   = 1'b1;
        bus.req = 4'b0000;
        drive_pats();

        // Grant, dwell, live pattern, drop to idle
        add(1, 4'b0000, 12'hA5A, 12'h000, 0, 0, 0);
        add(0, 4'b0001, 12'hA5A, 12'h000, 0, 0, 1);
        for (int i = 0; i < 5; i++) add(0, 4'b0001, 12'hA5A, 12'hA5A, 0, 1, 0);
        add(0, 4'b0001, 12'h001, 12'h001, 0, 1, 0);
        add(0, 4'b0001, 12'h002, 12'h002, 0, 1, 0);
        add(0, 4'b0001, 12'h004, 12'h004, 0, 1, 0);
        add(0, 4'b0000, 12'hA5A, 12'h000, 0, 0, 0);
        // Owner 2 keeps the bank through HOLD despite req[0]
        add(0, 4'b0100, 12'hA5A, 12'h000, 2, 0, 1);
        add(0, 4'b0100, 12'hA5A, 12'h00F, 2, 1, 0);
        for (int i = 0; i < 4; i++) add(0, 4'b0101, 12'hA5A, 12'h00F, 2, 1, 0);
        add(0, 4'b0101, 12'hA5A, 12'h000, 0, 0, 1);
        for (int i = 0; i < 5; i++) add(0, 4'b0001, 12'hA5A, 12'hA5A, 0, 1, 0);
        // Owner drops, lower source takes over, then 1 -> 3 -> idle
        add(0, 4'b0010, 12'hA5A, 12'h000, 1, 0, 1);
        for (int i = 0; i < 5; i++) add(0, 4'b0010, 12'hA5A, 12'h3C3, 1, 1, 0);
        add(0, 4'b1000, 12'hA5A, 12'h000, 3, 0, 1);
        for (int i = 0; i < 5; i++) add(0, 4'b1000, 12'hA5A, 12'hF00, 3, 1, 0);
        add(0, 4'b0000, 12'hA5A, 12'h000, 0, 0, 0);

        step();
        step();
        check_all("reset", 12'h000, 0, 0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            reset    = vecs[i].rst;
            bus.req  = vecs[i].req;
            pats[0]  = vecs[i].pat0;
            drive_pats();
            step();
            check_all($sformatf("row%0d", i), vecs[i].leds, vecs[i].owner,
                      vecs[i].valid, vecs[i].pulse);
        end

        // Reset while in HOLD, then a fresh grant must dwell the full time
        pats[0] = 12'hFFF;
        drive_pats();
        bus.req = 4'b0001;
        step();
        check("hold_rst.blank", bus.switch_pulse, 1);
        step();
        check("hold_rst.leds_fff", bus.leds, 12'hFFF);
        step();
        reset = 1'b1;
        step();
        check_all("hold_rst.after", 12'h000, 0, 0, 0);
        reset = 1'b0;
        step();
        check_all("regrant.blank", 12'h000, 0, 0, 1);
        bus.req = 4'b0010;
        for (int s = 0; s < 5; s++) begin
            step();
            check_all($sformatf("regrant.dwell%0d", s), 12'hFFF, 0, 1, 0);
        end
        step();
        check_all("regrant.handover", 12'h000, 1, 0, 1);

        reset   = 1'b1;
        bus.req = 4'b0000;
        pats[0] = 12'hA5A;
        drive_pats();
        step();
        reset = 1'b0;

        // All four at once, then peel them off from the top
        bus.req = 4'b1111;
        step();
        pulses = int'(bus.switch_pulse);
        check("all.first_owner", bus.owner, 0);
        for (int k = 0; k < 4; k++) begin
            for (int s = 0; s < 5; s++) begin
                step();
                pulses += int'(bus.switch_pulse);
            end
            check_all($sformatf("all.open%0d", k), pats[k], 2'(k), 1, 0);
            bus.req[k] = 1'b0;
            step();
            pulses += int'(bus.switch_pulse);
            if (k < 3) check_all($sformatf("all.hand%0d", k), 12'h000, 2'(k + 1), 0, 1);
            else       check_all("all.idle", 12'h000, 0, 0, 0);
        end
        check("all.pulse_count", pulses, 4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
